// File: rtl/sdpram_fifo_ctrl_pkg.sv
// Shared constants for the SDP-RAM FIFO controller and its output buffer.
// The RAM read latency sets both the in-flight pipeline length and the buffer depth.
package fifo_pkg;

    localparam int RD_LAT     = 3;
    localparam int OBUF_DEPTH = RD_LAT + 2;
    localparam int OBUF_CNT_W = $clog2(OBUF_DEPTH + 1);

    // One extra wrap bit so a full RAM region is distinguishable from an empty one.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sdpram_fifo_ctrl_if.sv
// Producer/consumer stream handshake of the FIFO controller.
// The controller uses the slave view; the environment driving it uses the master view.
interface sdpram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8
);

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data
    );

endinterface

// File: rtl/sdpram_fifo_obuf.sv
// Small circular buffer catching words returned by the RAM; head word is held in
// a register so the consumer sees a flop output that is stable under back-pressure.
module sdpram_fifo_obuf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [OBUF_CNT_W-1:0] count_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int IDX_W = $clog2(OBUF_DEPTH);
    typedef logic [IDX_W-1:0] idx_t;

    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    idx_t                  wr_q, wr_d, rd_q, rd_d;
    logic [OBUF_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  do_push, do_pop;

    function automatic idx_t next_idx(input idx_t i);
        return (i == idx_t'(OBUF_DEPTH - 1)) ? '0 : i + idx_t'(1);
    endfunction

    // A push into a buffer that is empty after this edge's pop becomes the new head directly.
    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && (cnt_q != OBUF_CNT_W'(OBUF_DEPTH));
        wr_d    = do_push ? next_idx(wr_q) : wr_q;
        rd_d    = do_pop ? next_idx(rd_q) : rd_q;
        cnt_d   = cnt_q + OBUF_CNT_W'(do_push) - OBUF_CNT_W'(do_pop);
        head_d  = head_q;
        if (do_push && (wr_q == rd_d)) begin
            head_d = push_data_i;
        end else if (cnt_d != '0) begin
            head_d = mem_q[rd_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else if (clr) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    assign count_o = cnt_q;
    assign valid_o = (cnt_q != '0);
    assign head_o  = head_q;

endmodule

// File: rtl/sdpram_fifo_ctrl.sv
// FIFO control stage in front of a simple dual-port RAM: pointers, occupancy and
// read-ahead issue, with the fixed RAM read latency absorbed by the output buffer.
module sdpram_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int MEM_DEPTH  = 16,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    sdpram_fifo_ctrl_if.slave     bus,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  ram_wena,
    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [DATA_WIDTH-1:0] ram_dina,
    output logic                  ram_renb,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [DATA_WIDTH-1:0] ram_doutb
);

    localparam int PTR_W  = ptr_width(MEM_DEPTH);
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int INF_W  = $clog2(RD_LAT + 1);
    localparam int PEND_W = OBUF_CNT_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t                  wptr_q, wptr_d, rptr_q, rptr_d, ram_level;
    logic [RD_LAT-1:0]     v_q, v_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [OBUF_CNT_W-1:0] obuf_count;
    logic [INF_W-1:0]      inflight;
    logic [PEND_W-1:0]     pending;
    logic                  accept, issue, pop;

    // Issue depends only on registered state, so every in-flight word is guaranteed a buffer slot.
    always_comb begin
        ram_level = wptr_q - rptr_q;
        full      = (ram_level == ptr_t'(MEM_DEPTH));
        accept    = bus.s_valid && bus.s_ready;
        inflight  = INF_W'($countones(v_q));
        pending   = PEND_W'(obuf_count) + PEND_W'(inflight);
        issue     = (ram_level != '0) && (pending < PEND_W'(OBUF_DEPTH));
        pop       = bus.m_valid && bus.m_ready;
        wptr_d    = accept ? wptr_q + ptr_t'(1) : wptr_q;
        rptr_d    = issue ? rptr_q + ptr_t'(1) : rptr_q;
        v_d       = {v_q[RD_LAT-2:0], issue};
        count_d   = count_q + CNT_W'(accept) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            v_q     <= '0;
            count_q <= '0;
        end else if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            v_q     <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    sdpram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .push_i      (v_q[RD_LAT-1]),
        .push_data_i (ram_doutb),
        .pop_i       (pop),
        .count_o     (obuf_count),
        .valid_o     (bus.m_valid),
        .head_o      (bus.m_data)
    );

    assign bus.s_ready = rst && !full;
    assign ram_wena    = accept;
    assign ram_addra   = wptr_q[ADDR_WIDTH-1:0];
    assign ram_dina    = bus.s_data;
    assign ram_renb    = issue;
    assign ram_addrb   = rptr_q[ADDR_WIDTH-1:0];
    assign count       = count_q;
    assign empty       = (count_q == '0);

endmodule
